// File: rtl/aes_key_expander_pkg.sv
// Shared types, constants and helpers for the AES key-schedule engine.
package aes_kx_pkg;

    localparam int unsigned KX_KEY_W  = 256;
    localparam int unsigned KX_WORD_W = 32;
    localparam int unsigned KX_MAX_RK = 15;
    localparam int unsigned KX_RK_W   = 128;
    localparam int unsigned KX_IDX_W  = 4;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_e;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'b01:   return 4'd6;
            2'b10:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    // Number of cipher rounds.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // GF(2^8) multiply by x, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Request/status/read-port bundle between key controller and key expander.
interface aes_kx_if;
    import aes_kx_pkg::*;

    logic                start;
    logic [1:0]          key_len;
    logic [KX_KEY_W-1:0] key;
    logic                busy;
    logic                done;
    logic                err;
    logic [3:0]          nr;
    logic [3:0]          rk_avail;
    logic [KX_IDX_W-1:0] rk_idx;
    logic [KX_RK_W-1:0]  rk_out;

    modport master (
        output start, key_len, key, rk_idx,
        input  busy, done, err, nr, rk_avail, rk_out
    );

    modport slave (
        input  start, key_len, key, rk_idx,
        output busy, done, err, nr, rk_avail, rk_out
    );

endinterface

// File: rtl/aes_key_expander_sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module aes_sub_word (
    input  logic [31:0] word,
    output logic [31:0] sub_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        sub_c = '0;
        for (int b = 0; b < 4; b++) begin
            sub_c[8*b +: 8] = SBOX[word[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one schedule word per clock, indexed round-key read.
module aes_key_expander
    import aes_kx_pkg::*;
#(
    parameter int unsigned KEY_W  = KX_KEY_W,
    parameter int unsigned MAX_RK = KX_MAX_RK,
    parameter int unsigned WORD_W = KX_WORD_W
) (
    input  logic      clk,
    input  logic      rst,
    aes_kx_if.slave   bus
);

    localparam int unsigned N_WORDS   = 4 * MAX_RK;
    localparam int unsigned KEY_WORDS = KEY_W / WORD_W;
    localparam int unsigned PTR_W     = 6;

    state_e              state;
    logic [WORD_W-1:0]   w [N_WORDS];
    logic [WORD_W-1:0]   key_w [KEY_WORDS];
    logic [PTR_W-1:0]    i;
    logic [2:0]          j;
    logic [3:0]          nk;
    logic [3:0]          nr;
    logic [3:0]          rk_avail;
    logic [7:0]          rcon;
    logic                busy;
    logic                done;
    logic                err;

    logic [3:0]          nk_sel_c;
    logic [WORD_W-1:0]   prev_c;
    logic [WORD_W-1:0]   sub_in_c;
    logic [WORD_W-1:0]   sub_c;
    logic [WORD_W-1:0]   temp_c;
    logic [WORD_W-1:0]   w_next_c;
    logic [PTR_W-1:0]    last_i_c;
    logic [3:0]          avail_next_c;
    logic [PTR_W-1:0]    base_c;

    // Key split into words, most significant word first.
    always_comb begin
        for (int k = 0; k < KEY_WORDS; k++) begin
            key_w[k] = bus.key[KEY_W-1-WORD_W*k -: WORD_W];
        end
    end

    assign nk_sel_c = nk_of(bus.key_len);
    assign prev_c   = w[i - PTR_W'(1)];
    assign sub_in_c = (j == 3'd0) ? {prev_c[WORD_W-9:0], prev_c[WORD_W-1 -: 8]} : prev_c;

    aes_sub_word u_sub_word (
        .word  (sub_in_c),
        .sub_c (sub_c)
    );

    always_comb begin
        temp_c = prev_c;
        if (j == 3'd0) begin
            temp_c = sub_c ^ {rcon, 24'h0};
        end else if (nk == 4'd8 && j == 3'd4) begin
            temp_c = sub_c;
        end
    end

    assign w_next_c     = w[i - PTR_W'(nk)] ^ temp_c;
    assign last_i_c     = PTR_W'((({2'b00, nr} + 6'd1) << 2) - 6'd1);
    assign avail_next_c = 4'((7'(i) + 7'd1) >> 2);

    // Controller and word array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            for (int k = 0; k < N_WORDS; k++) w[k] <= '0;
            i        <= '0;
            j        <= '0;
            nk       <= '0;
            nr       <= '0;
            rk_avail <= '0;
            rcon     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        if (bus.key_len == KL_BAD) begin
                            err <= 1'b1;
                        end else begin
                            for (int k = 0; k < N_WORDS; k++) w[k] <= '0;
                            for (int k = 0; k < KEY_WORDS; k++) begin
                                if (4'(k) < nk_sel_c) w[k] <= key_w[k];
                            end
                            nk       <= nk_sel_c;
                            nr       <= nr_of(bus.key_len);
                            i        <= PTR_W'(nk_sel_c);
                            j        <= '0;
                            rcon     <= RCON_INIT;
                            rk_avail <= nk_sel_c >> 2;
                            busy     <= 1'b1;
                            state    <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    w[i]     <= w_next_c;
                    rk_avail <= avail_next_c;
                    i        <= i + PTR_W'(1);
                    if (j == 3'd0) rcon <= xtime(rcon);
                    // j tracks i mod Nk without a divider.
                    if (4'(j) == nk - 4'd1) j <= '0;
                    else                    j <= j + 3'd1;
                    if (i == last_i_c) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;
    assign bus.nr       = nr;
    assign bus.rk_avail = rk_avail;

    // Round-key read; indices past Nr read as zero.
    assign base_c = {bus.rk_idx, 2'b00};
    always_comb begin
        bus.rk_out = '0;
        if (bus.rk_idx <= nr) begin
            bus.rk_out = {w[base_c], w[base_c + 6'd1], w[base_c + 6'd2], w[base_c + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed-vector bench for aes_key_expander using FIPS-197 key-expansion results.
module tb_aes_key_expander;
    import aes_kx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_kx_if bus();

    aes_key_expander dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [127:0] rk128 [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    // Pulse start around one rising edge; returns at the falling edge after acceptance.
    task automatic start_req(input logic [1:0] kl, input logic [255:0] k);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.key_len = kl;
        bus.key     = k;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.key_len = 2'b11;
        bus.key     = ~k;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        bus.rk_idx = idx;
        #1;
        v = bus.rk_out;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_rk(4'd0, v);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b exp 00", bus.done, bus.err); end
        checks++; if (bus.nr !== 4'd0) begin errors++; $display("FAIL reset_nr got %0d exp 0", bus.nr); end
        checks++; if (bus.rk_avail !== 4'd0) begin errors++; $display("FAIL reset_avail got %0d exp 0", bus.rk_avail); end
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL reset_rk0 got %h exp 0", v); end
    endtask

    task automatic test_aes128();
        int lat;
        logic [127:0] v;
        start_req(KL_128, K128);
        wait_done(lat);
        checks++; if (lat !== 40) begin errors++; $display("FAIL aes128_latency got %0d exp 40", lat); end
        checks++; if (bus.nr !== 4'd10) begin errors++; $display("FAIL aes128_nr got %0d exp 10", bus.nr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL aes128_busy got %b exp 0", bus.busy); end
        read_rk(4'd1, v);
        checks++; if (v !== rk128[1]) begin errors++; $display("FAIL aes128_rk1 got %h exp %h", v, rk128[1]); end
        read_rk(4'd10, v);
        checks++; if (v !== rk128[10]) begin errors++; $display("FAIL aes128_rk10 got %h exp %h", v, rk128[10]); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL aes128_done_pulse got %b exp 0", bus.done); end
        checks++; if (bus.rk_avail !== 4'd11) begin errors++; $display("FAIL aes128_avail got %0d exp 11", bus.rk_avail); end
    endtask

    task automatic test_aes192();
        int lat;
        logic [127:0] v;
        start_req(KL_192, K192);
        wait_done(lat);
        checks++; if (lat !== 46) begin errors++; $display("FAIL aes192_latency got %0d exp 46", lat); end
        checks++; if (bus.nr !== 4'd12) begin errors++; $display("FAIL aes192_nr got %0d exp 12", bus.nr); end
        read_rk(4'd12, v);
        checks++; if (v !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin errors++; $display("FAIL aes192_rk12 got %h exp a4970a331a78dc09c418c271e3a41d5d", v); end
        read_rk(4'd0, v);
        checks++; if (v !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL aes192_rk0 got %h exp 000102030405060708090a0b0c0d0e0f", v); end
    endtask

    task automatic test_aes256();
        int lat;
        logic [127:0] v;
        start_req(KL_256, K256);
        wait_done(lat);
        checks++; if (lat !== 52) begin errors++; $display("FAIL aes256_latency got %0d exp 52", lat); end
        checks++; if (bus.nr !== 4'd14) begin errors++; $display("FAIL aes256_nr got %0d exp 14", bus.nr); end
        checks++; if (bus.rk_avail !== 4'd15) begin errors++; $display("FAIL aes256_avail got %0d exp 15", bus.rk_avail); end
        read_rk(4'd14, v);
        checks++; if (v !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin errors++; $display("FAIL aes256_rk14 got %h exp 24fc79ccbf0979e9371ac23c6d68de36", v); end
        read_rk(4'd15, v);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL aes256_rk15 got %h exp 0", v); end
    endtask

    task automatic test_progressive();
        logic [127:0] v;
        logic [3:0]   exp_avail;
        start_req(KL_128, K128);
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) @(negedge clk);
            exp_avail = 4'((c + 4) >> 2);
            checks++; if (bus.rk_avail !== exp_avail) begin errors++; $display("FAIL prog_avail c=%0d got %0d exp %0d", c, bus.rk_avail, exp_avail); end
            read_rk(exp_avail - 4'd1, v);
            checks++; if (v !== rk128[exp_avail - 4'd1]) begin errors++; $display("FAIL prog_rk c=%0d idx=%0d got %h exp %h", c, exp_avail - 4'd1, v, rk128[exp_avail - 4'd1]); end
            checks++; if (bus.done !== (c == 40)) begin errors++; $display("FAIL prog_done c=%0d got %b", c, bus.done); end
            checks++; if (bus.busy !== (c < 40)) begin errors++; $display("FAIL prog_busy c=%0d got %b", c, bus.busy); end
        end
    endtask

    task automatic test_error();
        logic [127:0] v;
        start_req(2'b11, K256);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b exp 0", bus.busy); end
        checks++; if (bus.nr !== 4'd10) begin errors++; $display("FAIL err_nr got %0d exp 10", bus.nr); end
        read_rk(4'd10, v);
        checks++; if (v !== rk128[10]) begin errors++; $display("FAIL err_keys got %h exp %h", v, rk128[10]); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_width got %b exp 0", bus.err); end
        checks++; if (bus.rk_avail !== 4'd11) begin errors++; $display("FAIL err_avail got %0d exp 11", bus.rk_avail); end
    endtask

    task automatic test_ignore_mid_expand();
        int lat;
        logic [127:0] v;
        start_req(KL_128, K128);
        repeat (5) @(negedge clk);
        bus.start   = 1'b1;
        bus.key_len = KL_256;
        bus.key     = K256;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done(lat);
        checks++; if (lat + 6 !== 40) begin errors++; $display("FAIL ignore_latency got %0d exp 40", lat + 6); end
        checks++; if (bus.nr !== 4'd10) begin errors++; $display("FAIL ignore_nr got %0d exp 10", bus.nr); end
        read_rk(4'd10, v);
        checks++; if (v !== rk128[10]) begin errors++; $display("FAIL ignore_rk10 got %h exp %h", v, rk128[10]); end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [127:0] v;
        start_req(KL_256, K256);
        repeat (20) @(negedge clk);
        bus.rk_idx = 4'd0;
        #2;
        rst = 1'b1;
        #1;
        v = bus.rk_out;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL arst_busy_done got %b%b exp 00", bus.busy, bus.done); end
        checks++; if (bus.nr !== 4'd0) begin errors++; $display("FAIL arst_nr got %0d exp 0", bus.nr); end
        checks++; if (bus.rk_avail !== 4'd0) begin errors++; $display("FAIL arst_avail got %0d exp 0", bus.rk_avail); end
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL arst_rk0 got %h exp 0", v); end
        @(negedge clk);
        rst = 1'b0;
        start_req(KL_128, K128);
        wait_done(lat);
        checks++; if (lat !== 40) begin errors++; $display("FAIL arst_rerun_latency got %0d exp 40", lat); end
        read_rk(4'd1, v);
        checks++; if (v !== rk128[1]) begin errors++; $display("FAIL arst_rerun_rk1 got %h exp %h", v, rk128[1]); end
        read_rk(4'd10, v);
        checks++; if (v !== rk128[10]) begin errors++; $display("FAIL arst_rerun_rk10 got %h exp %h", v, rk128[10]); end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.key_len = 2'b00;
        bus.key     = '0;
        bus.rk_idx  = '0;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_progressive();
        test_error();
        test_ignore_mid_expand();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
